mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one four-input gate-level 4:1 mux between four requesters.
- Drives the mux select pair: sel[0] goes to s0 and sel[1] goes to s1. Input a is requester 0, b is 1, c is 2, d is 3.
- Grants are held until the owner drops its request. Rotating priority guarantees fairness.
- Sits between the requesting datapath blocks and the shared mux. It is the only driver of s0 and s1.

---
 rtl/mux4_arb_pkg.sv | 17 +
 rtl/rr_priority_picker.sv | 31 +++
 rtl/mux4_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Convert a requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority search: first masked request at or after ptr, wrapping mod 4.
module rr_priority_picker
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] w_cand;
  logic [IDX_W-1:0]   w_pos;

  assign w_cand = req & mask;

  // Walk from the farthest offset back to ptr so the nearest candidate wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    w_pos = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_pos = ptr + IDX_W'(i);
      if (w_cand[w_pos]) begin
        found = 1'b1;
        idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select lines of a shared 4:1 mux.
// Optional owner-timeout preemption is compiled in with MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   sel,
  output logic [IDX_W-1:0]   grant_idx_last
);

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e          r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_grant_valid;
  logic [IDX_W-1:0]    r_sel;
  logic [IDX_W-1:0]    r_last;

  arb_state_e          w_state_nxt;
  logic [IDX_W-1:0]    w_ptr_nxt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic [NUM_REQ-1:0]  w_grant_nxt;
  logic                w_valid_nxt;
  logic [IDX_W-1:0]    w_sel_nxt;
  logic [IDX_W-1:0]    w_last_nxt;

  logic [NUM_REQ-1:0]  w_owner_oh;
  logic                w_owner_req;
  logic                w_others;
  logic                w_preempt;
  logic [NUM_REQ-1:0]  w_mask;
  logic [HOLD_W-1:0]   w_hold_inc;
  logic                w_found;
  logic [IDX_W-1:0]    w_idx;

  // While owning, sel always holds the owner index.
  assign w_owner_oh  = idx2onehot(r_sel);
  assign w_owner_req = req[r_sel];
  assign w_others    = |(req & ~w_owner_oh);
  assign w_preempt   = TIMEOUT_EN && (r_state == OWN) && (r_hold_cnt == HOLD_LAST) && w_others;
  assign w_mask      = w_preempt ? ~w_owner_oh : {NUM_REQ{1'b1}};
  assign w_hold_inc  = (r_hold_cnt == {HOLD_W{1'b1}}) ? r_hold_cnt : r_hold_cnt + HOLD_W'(1);

  rr_priority_picker u_picker (
    .req   (req),
    .ptr   (r_ptr),
    .mask  (w_mask),
    .found (w_found),
    .idx   (w_idx)
  );

  // Next-state and next-output decision.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_grant_valid;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;

    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = OWN;
          w_grant_nxt = idx2onehot(w_idx);
          w_valid_nxt = 1'b1;
          w_sel_nxt   = w_idx;
          w_last_nxt  = w_idx;
          w_ptr_nxt   = w_idx + IDX_W'(1);
          w_hold_nxt  = '0;
        end
      end
      OWN: begin
        if (w_owner_req && !w_preempt) begin
          w_hold_nxt = w_hold_inc;
        end else if (w_found) begin
          w_grant_nxt = idx2onehot(w_idx);
          w_valid_nxt = 1'b1;
          w_sel_nxt   = w_idx;
          w_last_nxt  = w_idx;
          w_ptr_nxt   = w_idx + IDX_W'(1);
          w_hold_nxt  = '0;
        end else begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_hold_cnt    <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_sel         <= '0;
      r_last        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_valid <= w_valid_nxt;
      r_sel         <= w_sel_nxt;
      r_last        <= w_last_nxt;
    end
  end

  assign grant          = r_grant;
  assign grant_valid    = r_grant_valid;
  assign sel            = r_sel;
  assign grant_idx_last = r_last;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: per-cycle reference model plus directed literal checks.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 8;
  localparam int HOLD_SAT = 15;
`ifdef MUX4_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] sel;
  logic [1:0] grant_idx_last;

  int n_cmp = 0;
  int n_bad = 0;
  bit run = 1'b0;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .grant          (grant),
    .grant_valid    (grant_valid),
    .sel            (sel),
    .grant_idx_last (grant_idx_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 idle), rotating pointer, hold counter.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_last  = 0;
  int m_hold  = 0;

  function automatic int pick(input logic [3:0] r, input int p, input int excl);
    for (int o = 0; o < 4; o++) begin
      int c;
      c = (p + o) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_last = 0; m_hold = 0;
    end else begin
      bit pre;
      int w;
      pre = TO_EN && (m_owner >= 0) && (m_hold == MAX_HOLD - 1) &&
            ((req & ~(4'b0001 << m_owner)) != 4'b0000);
      if (m_owner >= 0 && req[m_owner] && !pre) begin
        m_hold = (m_hold < HOLD_SAT) ? m_hold + 1 : HOLD_SAT;
      end else begin
        w = pick(req, m_ptr, pre ? m_owner : -1);
        if (w >= 0) begin
          m_owner = w; m_ptr = (w + 1) % 4; m_last = w; m_sel = w; m_hold = 0;
        end else begin
          m_owner = -1;
        end
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("grant", 32'(grant), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
      chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
      chk("sel", 32'(sel), 32'(m_sel));
      chk("grant_idx_last", 32'(grant_idx_last), 32'(m_last));
    end
  end

  task automatic cyc(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(4'b0000);
    cyc(4'b0000);
    reset_n = 1'b1;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    cyc(4'b0000);
    cyc(4'b0000);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_sel", 32'(sel), 32'd0);
    chk("reset_valid", 32'(grant_valid), 32'd0);
    reset_n = 1'b1;
    run = 1'b1;

    // Basic grant then zero-bubble handover.
    cyc(4'b0101);
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_sel", 32'(sel), 32'd0);
    cyc(4'b0100);
    chk("handover_grant", 32'(grant), 32'h4);
    chk("handover_sel", 32'(sel), 32'd2);
    cyc(4'b0000);
    chk("idle_valid", 32'(grant_valid), 32'd0);
    chk("idle_sel_hold", 32'(sel), 32'd2);

    // Fairness with all requesting, each owner dropping after 2 cycles.
    do_reset();
    cyc(4'b1111);
    chk("fair_0", 32'(sel), 32'(exp_order[0]));
    for (int n = 1; n < 5; n++) begin
      cyc(4'b1111);
      cyc(4'b1111 & ~(4'b0001 << exp_order[n-1]));
      chk($sformatf("fair_%0d", n), 32'(sel), 32'(exp_order[n]));
    end

    // Owner 3 releases with nobody else waiting: sel must stay at 3.
    cyc(4'b1000);
    chk("own3_grant", 32'(grant), 32'h8);
    cyc(4'b0000);
    chk("idle3_grant", 32'(grant), 32'd0);
    chk("idle3_valid", 32'(grant_valid), 32'd0);
    chk("idle3_sel", 32'(sel), 32'd3);
    chk("idle3_last", 32'(grant_idx_last), 32'd3);

    // Owner 1 drops as requesters 0 and 2 rise: 2 wins from ptr=2.
    cyc(4'b0010);
    cyc(4'b0010);
    cyc(4'b0101);
    chk("simul_sel", 32'(sel), 32'd2);
    chk("simul_grant", 32'(grant), 32'h4);
    cyc(4'b0100);

    // Asynchronous reset between edges.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_valid", 32'(grant_valid), 32'd0);
    chk("async_sel", 32'(sel), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(4'b1010);
    chk("post_reset_sel", 32'(sel), 32'd1);

    // Owner 0 held, requester 1 waiting from cycle 2.
    do_reset();
    cyc(4'b0001);
    for (int i = 1; i <= 8; i++) begin
      cyc((i >= 2) ? 4'b0011 : 4'b0001);
      if (i == 7) chk("hold_7", 32'(grant), 32'h1);
    end
    chk("hold_8", 32'(grant), TO_EN ? 32'h2 : 32'h1);

    // Single requester may hold indefinitely.
    do_reset();
    for (int i = 0; i < 23; i++) cyc(4'b0001);
    chk("long_hold_grant", 32'(grant), 32'h1);
    chk("long_hold_valid", 32'(grant_valid), 32'd1);

    cyc(4'b0000);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
